// File: rtl/bram_port_arbiter.sv
// Purpose     : round-robin sharing of NUM_PORTS BRAM ports among NUM_REQ requesters.
// Latency     : grant is combinational in the request cycle; read data returns the next cycle.
// Backpressure: req_ready low holds a requester off; responses are never back-pressured.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_we/req_addr/req_wdata -> req_ready   : per-requester access handshake
//   rsp_valid/rsp_data                                  : per-requester read response
//   bram_addr/bram_we/bram_din -> bram_dout             : per-port BRAM interface (1-cycle read)
module bram_port_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_PORTS = 2,
    parameter int NUM_REQ   = 4,
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int PIW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0][AW-1:0]          req_addr,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [NUM_REQ-1:0][WIDTH-1:0]       rsp_data,
    output logic [NUM_PORTS-1:0][AW-1:0]        bram_addr,
    output logic [NUM_PORTS-1:0]                bram_we,
    output logic [NUM_PORTS-1:0][WIDTH-1:0]     bram_din,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]     bram_dout
);

    logic [IW-1:0]                     rr_ptr;
    logic [IW-1:0]                     rr_next;
    logic                              any_grant;
    logic [NUM_REQ-1:0]                ready_c;
    logic [NUM_PORTS-1:0]              port_vld;
    logic [NUM_PORTS-1:0]              port_we;
    logic [NUM_PORTS-1:0][AW-1:0]      port_addr;
    logic [NUM_PORTS-1:0][WIDTH-1:0]   port_din;
    logic [NUM_PORTS-1:0][IW-1:0]      port_idx;

    // One-cycle record of which requester each port served with a read,
    // used to steer bram_dout back when the synchronous read completes.
    logic [NUM_PORTS-1:0]              trk_vld;
    logic [NUM_PORTS-1:0][IW-1:0]      trk_idx;

    int                                cand_i;
    int                                n_grant;
    logic [IW-1:0]                     cand;
    logic                              conflict;

    // Scan requesters starting at rr_ptr; each accepted candidate takes the
    // next free port. A candidate colliding with an earlier grant on the same
    // address (unless both are reads) is skipped but the scan continues.
    always_comb begin
        ready_c   = '0;
        port_vld  = '0;
        port_we   = '0;
        port_addr = '0;
        port_din  = '0;
        port_idx  = '0;
        rr_next   = rr_ptr;
        any_grant = 1'b0;
        n_grant   = 0;
        cand_i    = 0;
        cand      = '0;
        conflict  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand_i = int'(rr_ptr) + j;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            cand     = IW'(cand_i);
            conflict = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (port_vld[k] && (port_addr[k] == req_addr[cand]) &&
                    (port_we[k] || req_we[cand])) begin
                    conflict = 1'b1;
                end
            end
            if (reset && req_valid[cand] && !conflict && (n_grant < NUM_PORTS)) begin
                ready_c[cand]                = 1'b1;
                port_vld[PIW'(n_grant)]      = 1'b1;
                port_we[PIW'(n_grant)]       = req_we[cand];
                port_addr[PIW'(n_grant)]     = req_addr[cand];
                port_din[PIW'(n_grant)]      = req_wdata[cand];
                port_idx[PIW'(n_grant)]      = cand;
                n_grant                      = n_grant + 1;
                any_grant                    = 1'b1;
                // Last grant in scan order wins, so the pointer lands just past it.
                rr_next                      = IW'((cand_i + 1) % NUM_REQ);
            end
        end
    end

    assign req_ready = ready_c;
    assign bram_we   = port_we;
    assign bram_addr = port_addr;
    assign bram_din  = port_din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            trk_vld <= '0;
            trk_idx <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
            trk_vld <= port_vld & ~port_we;
            trk_idx <= port_idx;
        end
    end

    // Each requester is granted at most once per cycle, so tracked indices never collide.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (trk_vld[k]) begin
                rsp_valid[trk_idx[k]] = 1'b1;
                rsp_data[trk_idx[k]]  = bram_dout[k];
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 32;
    localparam int NUM_PORTS = 2;
    localparam int NUM_REQ   = 4;
    localparam int AW        = $clog2(DEPTH);
    localparam int BOUND     = (NUM_REQ + NUM_PORTS - 1) / NUM_PORTS + 1;

    typedef logic [NUM_REQ-1:0][WIDTH-1:0] rdat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0][AW-1:0]         req_addr;
    logic [NUM_REQ-1:0][WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 rsp_valid;
    rdat_t                              rsp_data;
    logic [NUM_PORTS-1:0][AW-1:0]       bram_addr;
    logic [NUM_PORTS-1:0]               bram_we;
    logic [NUM_PORTS-1:0][WIDTH-1:0]    bram_din;
    logic [NUM_PORTS-1:0][WIDTH-1:0]    bram_dout;

    bram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] seed_word(input int d);
        return WIDTH'(32'hC001_0000 + 32'(d) * 32'h0101_0101);
    endfunction

    // Simple multi-port synchronous BRAM (read-first) driven by the DUT's ports.
    logic [WIDTH-1:0] bmem [DEPTH];
    always @(posedge clk) begin
        if (load) begin
            for (int d = 0; d < DEPTH; d++) bmem[d] <= seed_word(d);
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (bram_we[k]) bmem[bram_addr[k]] <= bram_din[k];
                bram_dout[k] <= bmem[bram_addr[k]];
            end
        end
    end

    // Reference model: pointer, memory contents, responses due next cycle.
    int                              m_ptr;
    logic [WIDTH-1:0]                m_mem [DEPTH];
    logic [NUM_REQ-1:0]              m_rsp_vld;
    rdat_t                           m_rsp_dat;
    int                              m_gq[$];
    logic [NUM_REQ-1:0]              exp_ready;
    logic [NUM_PORTS-1:0]            exp_we;
    logic [NUM_PORTS-1:0][AW-1:0]    exp_addr;
    logic [NUM_PORTS-1:0][WIDTH-1:0] exp_din;
    logic [NUM_REQ-1:0]              exp_rsp_vld;
    rdat_t                           exp_rsp_dat;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        m_ptr = 0; m_rsp_vld = '0; m_rsp_dat = '0;
    endtask

    task automatic model_eval();
        exp_ready = '0; exp_we = '0; exp_addr = '0; exp_din = '0;
        m_gq.delete();
        exp_rsp_vld = rst_n ? m_rsp_vld : '0;
        exp_rsp_dat = m_rsp_dat;
        if (!rst_n) return;
        for (int j = 0; j < NUM_REQ; j++) begin
            int r;
            bit clash;
            r = (m_ptr + j) % NUM_REQ;
            clash = 1'b0;
            foreach (m_gq[g])
                if (req_addr[m_gq[g]] == req_addr[r] && (req_we[m_gq[g]] || req_we[r])) clash = 1'b1;
            if (req_valid[r] && !clash && m_gq.size() < NUM_PORTS) m_gq.push_back(r);
        end
        foreach (m_gq[g]) begin
            exp_ready[m_gq[g]] = 1'b1;
            exp_we[g]   = req_we[m_gq[g]];
            exp_addr[g] = req_addr[m_gq[g]];
            exp_din[g]  = req_wdata[m_gq[g]];
        end
    endtask

    task automatic model_commit();
        m_rsp_vld = '0;
        if (!rst_n) begin m_ptr = 0; return; end
        foreach (m_gq[g])
            if (!req_we[m_gq[g]]) begin
                m_rsp_vld[m_gq[g]] = 1'b1;
                m_rsp_dat[m_gq[g]] = m_mem[req_addr[m_gq[g]]];
            end
        foreach (m_gq[g])
            if (req_we[m_gq[g]]) m_mem[req_addr[m_gq[g]]] = req_wdata[m_gq[g]];
        if (m_gq.size() > 0) m_ptr = (m_gq[m_gq.size()-1] + 1) % NUM_REQ;
    endtask

    function automatic rdat_t mask_dat(input logic [NUM_REQ-1:0] v, input rdat_t d);
        rdat_t o;
        o = '0;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) o[i] = d[i];
        return o;
    endfunction

    task automatic idle_inputs();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; idle_inputs(); model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pre();
        #1; model_eval();
    endtask

    task automatic step_end();
        @(posedge clk); model_commit(); @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid = '1; req_we = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            pre();
            n_cmp++;
            if ({req_ready, bram_we} !== '0 || {rsp_valid, rsp_data} !== '0) begin
                n_bad++;
                $display("FAIL reset_state: ready=%b we=%b rsp_vld=%b rsp_dat=%h, required all zero",
                         req_ready, bram_we, rsp_valid, rsp_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr_reads();
        logic [NUM_REQ-1:0] seq [4];
        seq = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        apply_reset();
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i] = AW'(i * 2);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) idle_inputs();
            pre();
            if (c < 4) begin
                n_cmp++;
                if (req_ready !== seq[c]) begin
                    n_bad++; $display("FAIL rr_ready c%0d: got %b, required %b", c, req_ready, seq[c]);
                end
            end
            n_cmp++;
            if ({req_ready, bram_we, bram_addr, bram_din} !== {exp_ready, exp_we, exp_addr, exp_din}) begin
                n_bad++; $display("FAIL rr_grant c%0d: ready=%b addr=%h, required ready=%b addr=%h",
                                  c, req_ready, bram_addr, exp_ready, exp_addr);
            end
            n_cmp++;
            if (rsp_valid !== exp_rsp_vld || mask_dat(rsp_valid, rsp_data) !== mask_dat(exp_rsp_vld, exp_rsp_dat)) begin
                n_bad++; $display("FAIL rr_rsp c%0d: vld=%b dat=%h, required vld=%b dat=%h",
                                  c, rsp_valid, rsp_data, exp_rsp_vld, mask_dat(exp_rsp_vld, exp_rsp_dat));
            end
            step_end();
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        req_valid = 4'b0011; req_we = 4'b0001;
        req_addr[0] = AW'(5); req_addr[1] = AW'(5); req_wdata[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_valid = 4'b0010;
            if (c == 2) idle_inputs();
            pre();
            n_cmp++;
            if ((c == 0 && {req_ready, bram_we} !== {4'b0001, 2'b01}) ||
                (c == 1 && {req_ready, bram_we} !== {4'b0010, 2'b00}) ||
                (c == 2 && (rsp_valid !== 4'b0010 || rsp_data[1] !== 32'hDEAD_BEEF))) begin
                n_bad++; $display("FAIL conflict c%0d: ready=%b we=%b rsp_vld=%b rsp1=%h, required ready=%b we=%b rsp_vld=%b rsp1=deadbeef",
                                  c, req_ready, bram_we, rsp_valid, rsp_data[1], exp_ready, exp_we, exp_rsp_vld);
            end
            n_cmp++;
            if ({req_ready, bram_we, bram_addr, bram_din} !== {exp_ready, exp_we, exp_addr, exp_din}) begin
                n_bad++; $display("FAIL conflict_grant c%0d: ready=%b din=%h, required ready=%b din=%h",
                                  c, req_ready, bram_din, exp_ready, exp_din);
            end
            step_end();
        end
    endtask

    task automatic test_same_addr();
        apply_reset();
        req_valid = 4'b1100; req_addr[2] = AW'(7); req_addr[3] = AW'(7);
        pre();
        n_cmp++;
        if (req_ready !== 4'b1100 || {req_ready, bram_addr} !== {exp_ready, exp_addr}) begin
            n_bad++; $display("FAIL same_addr_grant: ready=%b addr=%h, required ready=1100 addr=%h",
                              req_ready, bram_addr, exp_addr);
        end
        step_end();
        idle_inputs();
        pre();
        n_cmp++;
        if (rsp_valid !== 4'b1100 || rsp_data[2] !== m_mem[7] || rsp_data[3] !== m_mem[7]) begin
            n_bad++; $display("FAIL same_addr_rsp: vld=%b d2=%h d3=%h, required vld=1100 d=%h",
                              rsp_valid, rsp_data[2], rsp_data[3], m_mem[7]);
        end
        step_end();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 4'b0010; req_addr[1] = AW'(3);
        pre();
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL midrst_grant: ready=%b, required 0010", req_ready);
        end
        @(posedge clk); model_commit();
        #2;
        rst_n = 1'b0; model_reset();
        req_valid = 4'b0001; req_we = 4'b0001; req_addr[0] = AW'(3); req_wdata[0] = 32'h0BAD_F00D;
        #1;
        n_cmp++;
        if (rsp_valid !== '0 || rsp_data !== '0 || bram_we !== '0 || req_ready !== '0) begin
            n_bad++; $display("FAIL midrst_state: rsp_vld=%b we=%b ready=%b, required all zero",
                              rsp_valid, bram_we, req_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i] = AW'(i + 3);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) idle_inputs();
            pre();
            n_cmp++;
            if ((c == 0 && req_ready !== 4'b0011) ||
                rsp_valid !== exp_rsp_vld || mask_dat(rsp_valid, rsp_data) !== mask_dat(exp_rsp_vld, exp_rsp_dat)) begin
                n_bad++; $display("FAIL midrst_after c%0d: ready=%b vld=%b dat=%h, required ready=%b vld=%b dat=%h",
                                  c, req_ready, rsp_valid, rsp_data, exp_ready, exp_rsp_vld, mask_dat(exp_rsp_vld, exp_rsp_dat));
            end
            step_end();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int a = 0; a < 9; a++) begin
            if (a < 8) begin
                req_valid = 4'b1000; req_we = 4'b1000;
                req_addr[3] = AW'(a); req_wdata[3] = WIDTH'($urandom);
            end else idle_inputs();
            pre();
            if (a < 8) begin
                n_cmp++;
                if (req_ready !== 4'b1000 || bram_we !== 2'b01 || bram_addr[0] !== AW'(a) ||
                    bram_din[0] !== req_wdata[3]) begin
                    n_bad++; $display("FAIL b2b a%0d: ready=%b we=%b addr0=%h din0=%h, required 1000 01 %h %h",
                                      a, req_ready, bram_we, bram_addr[0], bram_din[0], AW'(a), req_wdata[3]);
                end
            end
            n_cmp++;
            if (rsp_valid !== '0) begin
                n_bad++; $display("FAIL b2b_rsp a%0d: rsp_vld=%b, required 0000", a, rsp_valid);
            end
            step_end();
        end
    endtask

    // Requests are held until accepted; only reads so no conflicts can block anyone.
    task automatic test_starvation();
        int waitc [NUM_REQ];
        logic [NUM_REQ-1:0] prev;
        apply_reset();
        prev = '0;
        for (int i = 0; i < NUM_REQ; i++) waitc[i] = 0;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    req_valid[i] = 1'b1; req_we[i] = 1'b0; req_addr[i] = AW'($urandom_range(0, DEPTH-1));
                end
            end
            pre();
            n_cmp++;
            if ({req_ready, bram_addr} !== {exp_ready, exp_addr} || rsp_valid !== exp_rsp_vld ||
                mask_dat(rsp_valid, rsp_data) !== mask_dat(exp_rsp_vld, exp_rsp_dat)) begin
                n_bad++; $display("FAIL starve_model c%0d: ready=%b vld=%b, required ready=%b vld=%b",
                                  c, req_ready, rsp_valid, exp_ready, exp_rsp_vld);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i]) begin
                    waitc[i]++;
                    if (req_ready[i] || waitc[i] > BOUND) begin
                        n_cmp++;
                        if (!req_ready[i]) begin
                            n_bad++; $display("FAIL starve_bound req%0d: waited %0d cycles, required <= %0d", i, waitc[i], BOUND);
                        end
                        waitc[i] = 0;
                    end
                end
            end
            prev = exp_ready;
            step_end();
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] prev;
        apply_reset();
        prev = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_we[i]    = 1'($urandom_range(0, 1));
                    req_addr[i]  = AW'($urandom_range(0, 7));
                    req_wdata[i] = WIDTH'($urandom);
                end
            end
            pre();
            n_cmp++;
            if ({req_ready, bram_we, bram_addr, bram_din} !== {exp_ready, exp_we, exp_addr, exp_din}) begin
                n_bad++; $display("FAIL rand_grant c%0d: ready=%b we=%b addr=%h din=%h, required ready=%b we=%b addr=%h din=%h",
                                  c, req_ready, bram_we, bram_addr, bram_din, exp_ready, exp_we, exp_addr, exp_din);
            end
            n_cmp++;
            if (rsp_valid !== exp_rsp_vld || mask_dat(rsp_valid, rsp_data) !== mask_dat(exp_rsp_vld, exp_rsp_dat)) begin
                n_bad++; $display("FAIL rand_rsp c%0d: vld=%b dat=%h, required vld=%b dat=%h",
                                  c, rsp_valid, rsp_data, exp_rsp_vld, mask_dat(exp_rsp_vld, exp_rsp_dat));
            end
            prev = exp_ready;
            step_end();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        for (int d = 0; d < DEPTH; d++) m_mem[d] = seed_word(d);
        load = 1'b1;
        @(negedge clk); @(negedge clk);
        load = 1'b0;
        test_reset();
        test_rr_reads();
        test_conflict();
        test_same_addr();
        test_reset_mid();
        test_back_to_back();
        test_starvation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 32, words in the shared BRAM.
REQ-003 SHALL have parameter NUM_PORTS, default 2, number of BRAM ports arbitrated.
REQ-004 SHALL have parameter NUM_REQ, default 4, number of requesters (NUM_REQ >= NUM_PORTS).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, [NUM_REQ], requester i presents an access.
REQ-008 SHALL have port req_we, input, [NUM_REQ], 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, [NUM_REQ] x $clog2(DEPTH), access address.
REQ-010 SHALL have port req_wdata, input, [NUM_REQ] x WIDTH, write data.
REQ-011 SHALL have port req_ready, output, [NUM_REQ], access accepted this cycle (combinational).
REQ-012 SHALL have port rsp_valid, output, [NUM_REQ], registered read data available.
REQ-013 SHALL have port rsp_data, output, [NUM_REQ] x WIDTH, read data for requester i.
REQ-014 SHALL have port bram_addr, output, [NUM_PORTS] x $clog2(DEPTH), BRAM address per port.
REQ-015 SHALL have port bram_we, output, [NUM_PORTS], BRAM write enable per port.
REQ-016 SHALL have port bram_din, output, [NUM_PORTS] x WIDTH, BRAM write data per port.
REQ-017 SHALL have port bram_dout, input, [NUM_PORTS] x WIDTH, BRAM read data (1-cycle synchronous read).

Function
REQ-018 A request SHALL transfer when req_valid[i] & req_ready[i] in the same cycle; req_ready SHALL never be high while req_valid is low.
REQ-019 Each cycle, valid requesters SHALL be scanned in round-robin order starting at pointer rr_ptr (wrapping NUM_REQ-1 -> 0); up to NUM_PORTS are granted, the k-th granted one driving BRAM port k.
REQ-020 Conflict rule: a candidate whose address equals that of an already-granted request in the same cycle, where either access is a write, SHALL NOT be granted (ready low); same-address read/read pairs both grant.
REQ-021 Unused ports SHALL drive bram_we = 0, bram_addr = 0, bram_din = 0.
REQ-022 bram_we[k] SHALL equal req_we of the requester granted on port k; bram_addr/bram_din likewise.
REQ-023 rr_ptr SHALL update to (index of last granted requester + 1) mod NUM_REQ when any grant occurs, else hold.
REQ-024 For a granted read by requester i on port k at cycle T, rsp_valid[i] SHALL be 1 in cycle T+1 only and rsp_data[i] SHALL equal bram_dout[k] in cycle T+1.
REQ-025 Granted writes SHALL produce no response; rsp_valid[i] SHALL be 0 in cycle T+1 after a write.
REQ-026 The block SHALL track per-port (valid, requester index) for one cycle to route bram_dout; no other buffering; responses are not back-pressured.
REQ-027 A requester held off SHALL keep its request and be granted no later than NUM_REQ/NUM_PORTS rounded up + 1 cycles when others contend without conflicts (starvation-free).
REQ-028 Back-to-back requests from one requester SHALL be accepted every cycle when uncontended.

Reset
REQ-029 While reset = 0: rr_ptr = 0, all rsp_valid = 0, rsp_data = 0, response tracking cleared, req_ready = 0, bram_we = 0.
REQ-030 Reset asserted mid-operation SHALL drop in-flight read responses (rsp_valid 0 in the following cycle) and suppress any write in that cycle.
REQ-031 After reset release the first arbitration SHALL start at requester 0.

Verification
REQ-032 After reset, req_valid=4'b1111 all reads, addr i*2 -> cycle0 ready=0011 (ports 0,1 = req0,req1), cycle1 ready=1100, cycle2 ready=0011; rsp_valid matches each ready one cycle later with bram_dout of the port.
REQ-033 req0 write addr 5 data 0xDEADBEEF and req1 read addr 5 same cycle -> ready=01 only, bram_we[0]=1; next cycle req1 granted, rsp_data[1]=0xDEADBEEF one cycle later.
REQ-034 req2 and req3 reads both addr 7, nothing else -> both granted same cycle, rsp_valid=1100 next cycle with equal data.
REQ-035 req1 read granted at T, reset pulled low at T+1 edge-asynchronously -> rsp_valid[1]=0, rr_ptr=0, bram_we=0 during reset.
REQ-036 req3 alone issues 8 consecutive writes addr 0..7 -> ready high all 8 cycles, always on port 0, no rsp_valid.
